// File: rtl/obb_bank.sv
// obb_bank: register bank of N_OBJ oriented-bounding-box bodies (x, y, vx, vy, theta, omega).
// A rising edge on frame_tick starts one update pass. The pass walks the bank one body at a
// time. For each active body it adds velocity to position, bounces off the walls, and
// advances the angle.
//
// Ports:
//   clk, reset             system clock; synchronous active-high reset
//   frame_tick             frame strobe; only its rising edge starts a pass
//   load_en, load_idx,
//   load_active, load_*    write one whole body while idle
//   load_ready             high when a load would be accepted (== ~busy)
//   rd_idx -> rd_x, rd_y,
//   rd_theta, rd_active    registered read port, 1-cycle latency
//   busy                   update pass in progress
//   pass_done              1-cycle pulse in the final cycle of a pass
//   frame_count            completed passes (wrapping)
//   overrun                ticks dropped while busy (saturating)
module obb_bank #(
  parameter int unsigned N_OBJ     = 4,
  parameter int unsigned WIDTH     = 24,
  parameter int unsigned FRAC_BITS = 8,
  parameter int unsigned ANG_W     = 16,
  parameter int unsigned X_MAX     = 639,
  parameter int unsigned Y_MAX     = 479,
  localparam int unsigned IDX_W    = $clog2(N_OBJ)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_tick,
  input  logic             load_en,
  input  logic [IDX_W-1:0] load_idx,
  input  logic             load_active,
  input  logic [WIDTH-1:0] load_x,
  input  logic [WIDTH-1:0] load_y,
  input  logic [WIDTH-1:0] load_vx,
  input  logic [WIDTH-1:0] load_vy,
  input  logic [ANG_W-1:0] load_theta,
  input  logic [ANG_W-1:0] load_omega,
  output logic             load_ready,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [WIDTH-1:0] rd_x,
  output logic [WIDTH-1:0] rd_y,
  output logic [ANG_W-1:0] rd_theta,
  output logic             rd_active,
  output logic             busy,
  output logic             pass_done,
  output logic [15:0]      frame_count,
  output logic [7:0]       overrun
);

  typedef struct packed {
    logic             active;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] vx;
    logic [WIDTH-1:0] vy;
    logic [ANG_W-1:0] theta;
    logic [ANG_W-1:0] omega;
  } body_t;

  typedef enum logic [1:0] {StIdle, StFetch, StCommit, StDone} state_e;

  // Walls in fixed point, one bit wider than the data so the comparisons are signed-safe.
  localparam logic signed [WIDTH:0] XMaxFx = (WIDTH+1)'(X_MAX << FRAC_BITS);
  localparam logic signed [WIDTH:0] YMaxFx = (WIDTH+1)'(Y_MAX << FRAC_BITS);
  localparam logic [IDX_W-1:0]      LastIdx = IDX_W'(N_OBJ - 1);

  body_t            bank_q [N_OBJ];
  body_t            bank_d [N_OBJ];
  body_t            work_q, work_d;
  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             tick_q;
  logic             busy_q, busy_d;
  logic             pass_done_q, pass_done_d;
  logic [15:0]      frame_count_q, frame_count_d;
  logic [7:0]       overrun_q, overrun_d;
  body_t            rd_q, rd_d;
  logic             tick_edge;
  logic             load_idx_ok, rd_idx_ok;

  // With a power-of-two bank every index value is legal, so no range check is built.
  if ((1 << IDX_W) == N_OBJ) begin : g_idx_full
    assign load_idx_ok = 1'b1;
    assign rd_idx_ok   = 1'b1;
  end else begin : g_idx_partial
    assign load_idx_ok = (32'(load_idx) < N_OBJ);
    assign rd_idx_ok   = (32'(rd_idx) < N_OBJ);
  end

  // One frame step for one body. Inactive bodies pass through unchanged.
  function automatic body_t integrate(input body_t b);
    body_t                  r;
    logic signed [WIDTH:0]  nx;
    logic signed [WIDTH:0]  ny;
    r  = b;
    nx = $signed({b.x[WIDTH-1], b.x}) + $signed({b.vx[WIDTH-1], b.vx});
    ny = $signed({b.y[WIDTH-1], b.y}) + $signed({b.vy[WIDTH-1], b.vy});
    if (b.active) begin
      // A position exactly on a wall is in range and does not bounce.
      if (nx[WIDTH]) begin
        r.x  = '0;
        r.vx = -b.vx;
      end else if (nx > XMaxFx) begin
        r.x  = XMaxFx[WIDTH-1:0];
        r.vx = -b.vx;
      end else begin
        r.x = nx[WIDTH-1:0];
      end
      if (ny[WIDTH]) begin
        r.y  = '0;
        r.vy = -b.vy;
      end else if (ny > YMaxFx) begin
        r.y  = YMaxFx[WIDTH-1:0];
        r.vy = -b.vy;
      end else begin
        r.y = ny[WIDTH-1:0];
      end
      r.theta = b.theta + b.omega;
    end
    return r;
  endfunction

  assign tick_edge = frame_tick & ~tick_q;

  always_comb begin
    bank_d        = bank_q;
    work_d        = work_q;
    state_d       = state_q;
    idx_d         = idx_q;
    frame_count_d = frame_count_q;
    overrun_d     = overrun_q;
    rd_d          = rd_idx_ok ? bank_q[rd_idx] : '0;

    unique case (state_q)
      StIdle: begin
        if (tick_edge) begin
          state_d = StFetch;
          idx_d   = '0;
        end
      end
      StFetch: begin
        work_d  = bank_q[idx_q];
        state_d = StCommit;
      end
      StCommit: begin
        bank_d[idx_q] = integrate(work_q);
        if (idx_q == LastIdx) begin
          state_d = StDone;
        end else begin
          state_d = StFetch;
          idx_d   = idx_q + IDX_W'(1);
        end
      end
      StDone: begin
        frame_count_d = frame_count_q + 16'd1;
        state_d       = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (tick_edge && state_q != StIdle && overrun_q != 8'hFF) begin
      overrun_d = overrun_q + 8'd1;
    end

    // Loads only happen in idle. A load in the same cycle as a tick edge lands before
    // the pass fetches anything, so the new pass sees it.
    if (load_en && !busy_q && load_idx_ok) begin
      bank_d[load_idx] = '{active: load_active, x: load_x, y: load_y, vx: load_vx,
                           vy: load_vy, theta: load_theta, omega: load_omega};
    end

    busy_d      = (state_d != StIdle);
    pass_done_d = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bank_q        <= '{default: '0};
      work_q        <= '0;
      state_q       <= StIdle;
      idx_q         <= '0;
      tick_q        <= 1'b0;
      busy_q        <= 1'b0;
      pass_done_q   <= 1'b0;
      frame_count_q <= '0;
      overrun_q     <= '0;
      rd_q          <= '0;
    end else begin
      bank_q        <= bank_d;
      work_q        <= work_d;
      state_q       <= state_d;
      idx_q         <= idx_d;
      tick_q        <= frame_tick;
      busy_q        <= busy_d;
      pass_done_q   <= pass_done_d;
      frame_count_q <= frame_count_d;
      overrun_q     <= overrun_d;
      rd_q          <= rd_d;
    end
  end

  assign load_ready  = ~busy_q;
  assign busy        = busy_q;
  assign pass_done   = pass_done_q;
  assign frame_count = frame_count_q;
  assign overrun     = overrun_q;
  assign rd_x        = rd_q.x;
  assign rd_y        = rd_q.y;
  assign rd_theta    = rd_q.theta;
  assign rd_active   = rd_q.active;

endmodule

// File: tb/tb_obb_bank.sv
// Directed bench for obb_bank (N_OBJ=4, WIDTH=24, FRAC_BITS=8, ANG_W=16, 639x479 walls).
module tb_obb_bank;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_tick = 1'b0;
  logic        load_en = 1'b0;
  logic [1:0]  load_idx = '0;
  logic        load_active = 1'b0;
  logic [23:0] load_x = '0, load_y = '0, load_vx = '0, load_vy = '0;
  logic [15:0] load_theta = '0, load_omega = '0;
  logic        load_ready;
  logic [1:0]  rd_idx = '0;
  logic [23:0] rd_x, rd_y;
  logic [15:0] rd_theta;
  logic        rd_active;
  logic        busy, pass_done;
  logic [15:0] frame_count;
  logic [7:0]  overrun;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  obb_bank #(
    .N_OBJ(4), .WIDTH(24), .FRAC_BITS(8), .ANG_W(16), .X_MAX(639), .Y_MAX(479)
  ) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick),
    .load_en(load_en), .load_idx(load_idx), .load_active(load_active),
    .load_x(load_x), .load_y(load_y), .load_vx(load_vx), .load_vy(load_vy),
    .load_theta(load_theta), .load_omega(load_omega), .load_ready(load_ready),
    .rd_idx(rd_idx), .rd_x(rd_x), .rd_y(rd_y), .rd_theta(rd_theta), .rd_active(rd_active),
    .busy(busy), .pass_done(pass_done), .frame_count(frame_count), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int idx, input logic act, input logic [23:0] x, input logic [23:0] y,
                      input logic [23:0] vx, input logic [23:0] vy,
                      input logic [15:0] th, input logic [15:0] om);
    load_idx = 2'(idx); load_active = act;
    load_x = x; load_y = y; load_vx = vx; load_vy = vy;
    load_theta = th; load_omega = om;
    load_en = 1'b1;
    step();
    load_en = 1'b0;
  endtask

  task automatic rd(input int idx);
    rd_idx = 2'(idx);
    step();
  endtask

  // One tick, then count busy cycles and pass_done pulses until idle (bounded).
  task automatic run_pass(output int bc, output int pc);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    bc = 0;
    pc = 0;
    for (int k = 0; k < 50 && busy; k++) begin
      bc++;
      if (pass_done) pc++;
      step();
    end
  endtask

  initial begin
    int bc, pc;

    // T1: reset state
    step(); step();
    reset = 1'b0;
    step();
    chk("t1_busy", busy, 0);
    chk("t1_load_ready", load_ready, 1);
    chk("t1_frame_count", frame_count, 0);
    chk("t1_overrun", overrun, 0);
    chk("t1_pass_done", pass_done, 0);
    for (int i = 0; i < 4; i++) begin
      rd(i);
      chk($sformatf("t1_rd_x%0d", i), rd_x, 0);
      chk($sformatf("t1_rd_theta%0d", i), rd_theta, 0);
      chk($sformatf("t1_rd_active%0d", i), rd_active, 0);
    end

    // T2: x=100.0, vx=-0.5 -> 99.5, busy for 2*N_OBJ+1 cycles
    load(1, 1'b1, 24'h006400, 24'h000000, 24'hFFFF80, 24'h000000, 16'h0, 16'h0);
    run_pass(bc, pc);
    chk("t2_busy_cycles", bc, 9);
    chk("t2_pass_done_pulses", pc, 1);
    chk("t2_frame_count", frame_count, 1);
    rd(1);
    chk("t2_rd_x", rd_x, 24'h006380);
    chk("t2_rd_active", rd_active, 1);

    // T3: left wall bounce on x, bottom wall bounce on y
    load(0, 1'b1, 24'h000100, 24'h01DE00, 24'hFFFD00, 24'h000200, 16'h0, 16'h0);
    run_pass(bc, pc);
    rd(0);
    chk("t3_x_clamp0", rd_x, 24'h000000);
    chk("t3_y_clamp479", rd_y, 24'h01DF00);
    run_pass(bc, pc);
    rd(0);
    chk("t3_x_after_bounce", rd_x, 24'h000300);
    chk("t3_y_after_bounce", rd_y, 24'h01DD00);
    chk("t3_frame_count", frame_count, 3);

    // T4: angle wrap both directions; x landing exactly on the right wall
    load(2, 1'b1, 24'h0, 24'h0, 24'h0, 24'h0, 16'hFFF0, 16'h0020);
    load(3, 1'b1, 24'h027E00, 24'h0, 24'h000100, 24'h0, 16'h0, 16'h0);
    run_pass(bc, pc);
    rd(2);
    chk("t4_theta_wrap_up", rd_theta, 16'h0010);
    rd(3);
    chk("t4_x_on_wall", rd_x, 24'h027F00);
    load(2, 1'b1, 24'h0, 24'h0, 24'h0, 24'h0, 16'h0010, 16'hFFE0);
    run_pass(bc, pc);
    rd(2);
    chk("t4_theta_wrap_down", rd_theta, 16'hFFF0);
    rd(3);
    chk("t4_x_clamp639", rd_x, 24'h027F00);
    run_pass(bc, pc);
    rd(3);
    chk("t4_x_after_right_bounce", rd_x, 24'h027E00);
    chk("t4_frame_count", frame_count, 6);

    // T5: tick and load mid-pass are dropped / ignored
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    chk("t5_busy_started", busy, 1);
    chk("t5_load_ready_low", load_ready, 0);
    step();
    frame_tick = 1'b1;
    load_idx = 2'd0; load_active = 1'b1; load_x = 24'h123456; load_y = 24'h0;
    load_vx = 24'h0; load_vy = 24'h0; load_theta = 16'h0; load_omega = 16'h0;
    load_en = 1'b1;
    step();
    frame_tick = 1'b0;
    load_en = 1'b0;
    pc = 0;
    for (int k = 0; k < 50 && busy; k++) begin
      if (pass_done) pc++;
      step();
    end
    chk("t5_idle_after_pass", busy, 0);
    chk("t5_overrun", overrun, 1);
    chk("t5_pass_done_pulses", pc, 1);
    chk("t5_frame_count", frame_count, 7);
    rd(0);
    chk("t5_x_not_loaded", rd_x, 24'h000F00);
    chk("t5_y", rd_y, 24'h01D500);
    // Flood of ticks: passes keep starting, most edges land while busy
    for (int k = 0; k < 3000; k++) begin
      frame_tick = ~frame_tick;
      step();
    end
    frame_tick = 1'b0;
    for (int k = 0; k < 50 && busy; k++) step();
    chk("t5_overrun_saturated", overrun, 8'hFF);

    // T6: inactive body untouched; reset in the middle of a pass
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t6_overrun_cleared", overrun, 0);
    load(0, 1'b0, 24'h000A00, 24'h000A00, 24'h000500, 24'h000500, 16'h1234, 16'h0100);
    for (int p = 0; p < 3; p++) run_pass(bc, pc);
    chk("t6_frame_count3", frame_count, 3);
    rd(0);
    chk("t6_inactive_x", rd_x, 24'h000A00);
    chk("t6_inactive_y", rd_y, 24'h000A00);
    chk("t6_inactive_theta", rd_theta, 16'h1234);
    chk("t6_inactive_flag", rd_active, 0);
    load(1, 1'b1, 24'h000100, 24'h0, 24'h000100, 24'h0, 16'h0, 16'h0);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    for (int k = 0; k < 4; k++) step();
    chk("t6_busy_at_fetch2", busy, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t6_busy_after_reset", busy, 0);
    chk("t6_frame_count_after_reset", frame_count, 0);
    pc = 0;
    for (int k = 0; k < 12; k++) begin
      if (pass_done) pc++;
      step();
    end
    chk("t6_no_pass_done", pc, 0);
    rd(0);
    chk("t6_idx0_cleared", rd_x, 0);
    rd(1);
    chk("t6_idx1_cleared_x", rd_x, 0);
    chk("t6_idx1_cleared_active", rd_active, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
